posit_random_bits_source: RTL and testbench

Produces the random-bit words consumed by the posit stochastic rounder on its `randomBits` input. The generator is a 32-bit Galois LFSR that advances OUT_WIDTH steps per accepted word, so consecutive words never reuse bits. A warm-up state machine discards the first words after reset or reseed. Output uses a valid/ready handshake so one source can feed a stalling rounding pipeline.

---
 rtl/posit_random_bits_source.sv | 82 ++++++++
 tb/tb_posit_random_bits_source.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/posit_random_bits_source.sv
// Random-bit word source for the posit stochastic rounder: 32-bit Galois LFSR
// advanced OUT_WIDTH steps per accepted word, with post-reset/reseed warm-up.
module posit_random_bits_source #(
  parameter int          OUT_WIDTH    = 9,
  parameter int          WARMUP_WORDS = 4,
  parameter logic [31:0] DEFAULT_SEED = 32'hACE1_2468
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 seedValid,
  input  logic [31:0]          seedData,
  input  logic                 outReady,
  output logic                 outValid,
  output logic [OUT_WIDTH-1:0] outBits,
  output logic                 warmingUp
);

  // state  | meaning
  // WARMUP | discarding WARMUP_WORDS words after reset/reseed, outValid low
  // RUN    | presenting words, advancing only on an accepted handshake

  localparam logic [31:0] POLY      = 32'h8020_0003;
  localparam bit          NO_WARMUP = (WARMUP_WORDS == 0);
  localparam logic [7:0]  WARM_LAST = 8'((WARMUP_WORDS == 0) ? 0 : WARMUP_WORDS - 1);

  typedef enum logic {S_WARMUP, S_RUN} state_t;

  state_t      state;
  logic [31:0] lfsr;
  logic [31:0] lfsr_next;
  logic [31:0] seed_eff;
  logic [7:0]  warm_count;

  function automatic logic [31:0] advance(input logic [31:0] s_in);
    logic [31:0] s;
    s = s_in;
    for (int i = 0; i < OUT_WIDTH; i++) begin
      s = {1'b0, s[31:1]} ^ (s[0] ? POLY : 32'h0);
    end
    return s;
  endfunction

  always_comb begin
    lfsr_next = advance(lfsr);
    // A zero seed would lock the LFSR at zero forever.
    seed_eff  = (seedData == 32'h0) ? DEFAULT_SEED : seedData;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lfsr       <= DEFAULT_SEED;
      warm_count <= 8'd0;
      state      <= NO_WARMUP ? S_RUN : S_WARMUP;
      outValid   <= NO_WARMUP;
    end else if (seedValid) begin
      // Reseed wins over any coinciding handshake; that word is dropped.
      lfsr       <= seed_eff;
      warm_count <= 8'd0;
      state      <= NO_WARMUP ? S_RUN : S_WARMUP;
      outValid   <= NO_WARMUP;
    end else begin
      case (state)
        S_WARMUP: begin
          lfsr       <= lfsr_next;
          warm_count <= warm_count + 8'd1;
          if (warm_count == WARM_LAST) begin
            state    <= S_RUN;
            outValid <= 1'b1;
          end
        end
        S_RUN: begin
          if (outValid && outReady) lfsr <= lfsr_next;
        end
        default: state <= S_WARMUP;
      endcase
    end
  end

  assign outBits   = lfsr[OUT_WIDTH-1:0];
  assign warmingUp = (state == S_WARMUP);

endmodule

// File: tb/tb_posit_random_bits_source.sv
// Randomized bench for posit_random_bits_source against a word-level model
// of the seed / warm-up / handshake rules, plus a zero-warmup 1-bit instance.
module tb_posit_random_bits_source;

  localparam int          OW   = 9;
  localparam int          WW   = 4;
  localparam logic [31:0] DEF  = 32'hACE1_2468;
  localparam logic [31:0] POLY = 32'h8020_0003;

  logic          clock = 1'b0;
  logic          reset;
  logic          seedValid;
  logic [31:0]   seedData;
  logic          outReady;
  logic          outValid;
  logic [OW-1:0] outBits;
  logic          warmingUp;

  logic          seed1_valid;
  logic [31:0]   seed1_data;
  logic          ready1;
  logic          valid1;
  logic [0:0]    bits1;
  logic          warm1;

  int n_compared   = 0;
  int n_mismatched = 0;

  // model: current LFSR value, output valid, warm-up flag, words left to discard
  logic [31:0] m_lfsr;
  logic        m_valid;
  logic        m_warm;
  int          m_left;

  always #5 clock = ~clock;

  posit_random_bits_source #(.OUT_WIDTH(OW), .WARMUP_WORDS(WW), .DEFAULT_SEED(DEF)) u_dut (
    .clock(clock), .reset(reset), .seedValid(seedValid), .seedData(seedData),
    .outReady(outReady), .outValid(outValid), .outBits(outBits), .warmingUp(warmingUp));

  posit_random_bits_source #(.OUT_WIDTH(1), .WARMUP_WORDS(0), .DEFAULT_SEED(DEF)) u_dut1 (
    .clock(clock), .reset(reset), .seedValid(seed1_valid), .seedData(seed1_data),
    .outReady(ready1), .outValid(valid1), .outBits(bits1), .warmingUp(warm1));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] words_after(input logic [31:0] s0, input int words);
    logic [31:0] s;
    s = s0;
    for (int i = 0; i < words * OW; i++) begin
      if (s[0]) s = (s >> 1) ^ POLY;
      else      s = s >> 1;
    end
    return s;
  endfunction

  task automatic model_reset();
    m_lfsr  = DEF;
    m_left  = WW;
    m_warm  = (WW != 0);
    m_valid = (WW == 0);
  endtask

  task automatic model_edge();
    if (seedValid) begin
      m_lfsr  = (seedData == 0) ? DEF : seedData;
      m_left  = WW;
      m_warm  = (WW != 0);
      m_valid = (WW == 0);
    end else if (m_warm) begin
      m_lfsr = words_after(m_lfsr, 1);
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_warm  = 1'b0;
        m_valid = 1'b1;
      end
    end else if (m_valid && outReady) begin
      m_lfsr = words_after(m_lfsr, 1);
    end
  endtask

  task automatic check_dut();
    check_eq("valid", 32'(outValid), 32'(m_valid));
    check_eq("bits", 32'(outBits), 32'(m_lfsr[OW-1:0]));
    check_eq("warming", 32'(warmingUp), 32'(m_warm));
  endtask

  task automatic cycle();
    @(posedge clock);
    model_edge();
    #1;
    check_dut();
  endtask

  // Called shortly after an edge; reset effect must be visible before the next edge.
  task automatic reset_pulse();
    logic [31:0] d;
    d = DEF;
    #3 reset = 1'b0;
    #1;
    check_eq("rst_valid", 32'(outValid), 32'(WW == 0));
    check_eq("rst_warming", 32'(warmingUp), 32'(WW != 0));
    check_eq("rst_bits", 32'(outBits), 32'(d[OW-1:0]));
    check_eq("rst_u1_valid", 32'(valid1), 32'd1);
    model_reset();
    #2 reset = 1'b1;
  endtask

  initial begin
    int          accepted;
    int          budget;
    int          below;
    int          ones [OW];
    logic [31:0] w;

    reset = 1'b0; seedValid = 1'b0; seedData = '0; outReady = 1'b1;
    seed1_valid = 1'b0; seed1_data = '0; ready1 = 1'b0;
    model_reset();
    #11;
    check_dut();
    check_eq("u1_reset_valid", 32'(valid1), 32'd1);
    check_eq("u1_reset_warm", 32'(warm1), 32'd0);
    reset = 1'b1;

    // warm-up from reset: valid rises after exactly WW edges
    for (int i = 0; i < WW; i++) cycle();
    w = words_after(DEF, WW);
    check_eq("first_word", 32'(outBits), 32'(w[OW-1:0]));
    check_eq("first_valid", 32'(outValid), 32'd1);

    // 1-bit, no-warmup instance: seed 1 gives 1, 1, 0
    seed1_valid = 1'b1; seed1_data = 32'h1; ready1 = 1'b1;
    cycle();
    seed1_valid = 1'b0;
    check_eq("u1_seed_valid", 32'(valid1), 32'd1);
    check_eq("u1_bit0", 32'(bits1), 32'd1);
    cycle();
    check_eq("u1_bit1", 32'(bits1), 32'd1);
    cycle();
    check_eq("u1_bit2", 32'(bits1), 32'd0);
    check_eq("u1_bit3_pending", 32'(valid1), 32'd1);
    ready1 = 1'b0;

    // stall: 10 cycles without ready, then resume
    outReady = 1'b0;
    w = 32'(outBits);
    for (int i = 0; i < 10; i++) cycle();
    check_eq("stall_hold", 32'(outBits), w);
    outReady = 1'b1;
    cycle();
    cycle();

    // zero seed behaves as DEFAULT_SEED
    seedValid = 1'b1; seedData = 32'h0;
    cycle();
    seedValid = 1'b0;
    for (int i = 0; i < WW; i++) cycle();
    w = words_after(DEF, WW);
    check_eq("zero_seed_word", 32'(outBits), 32'(w[OW-1:0]));

    // reseed coinciding with an accepted handshake
    outReady = 1'b1; seedValid = 1'b1; seedData = 32'h1234_5678;
    cycle();
    seedValid = 1'b0;
    check_eq("coincide_valid", 32'(outValid), 32'd0);
    for (int i = 0; i < WW; i++) cycle();
    w = words_after(32'h1234_5678, WW);
    check_eq("coincide_word", 32'(outBits), 32'(w[OW-1:0]));

    // reset mid-warmup (after 2 edges) and mid-stream
    seedValid = 1'b1; seedData = 32'hDEAD_BEEF;
    cycle();
    seedValid = 1'b0;
    cycle();
    cycle();
    reset_pulse();
    for (int i = 0; i < WW + 3; i++) cycle();
    reset_pulse();
    for (int i = 0; i < WW + 3; i++) cycle();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      outReady  = ($urandom_range(0, 3) != 0);
      seedValid = ($urandom_range(0, 49) == 0);
      seedData  = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      cycle();
      if ($urandom_range(0, 199) == 0) reset_pulse();
    end
    seedValid = 1'b0;

    // statistics over 1000 accepted words from DEFAULT_SEED
    reset_pulse();
    outReady = 1'b1;
    accepted = 0; budget = 0; below = 0;
    for (int b = 0; b < OW; b++) ones[b] = 0;
    while (accepted < 1000 && budget < 2000) begin
      if (outValid && outReady) begin
        accepted++;
        if (outBits < OW'(1 << (OW - 2))) below++;
        for (int b = 0; b < OW; b++) ones[b] += int'(outBits[b]);
      end
      cycle();
      budget++;
    end
    check_eq("stat_words", 32'(accepted), 32'd1000);
    check_eq("stat_round_up_65", 32'(below >= 200 && below <= 300), 32'd1);
    for (int b = 0; b < OW; b++)
      check_eq($sformatf("stat_ones_bit%0d", b), 32'(ones[b] >= 450 && ones[b] <= 550), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
